axi_lite_ch_fifo: RTL and testbench
===================================

Name: axi_lite_ch_fifo

Overview:
Parametrised AXI-lite channel receiver. It accepts beats on a VALID/READY slave port and buffers them in a DEPTH-entry circular FIFO. Beats are presented to the local register logic on a valid/ack port, which allows local back-pressure. It replaces the single-beat channel handshake on the AW/W/AR channels and sits between the AXI-lite interconnect and the local register bank. Optional AUTO_POP mode reproduces the legacy one-cycle cs pulse per transferred beat.

Parameters:
DATA_W, 32, width of the channel payload (address or data+strobe, packed by the caller)
DEPTH, 4, FIFO entries; power of two, >= 2
AUTO_POP, 0, 1 = every beat is presented for exactly one cycle on m_cs and popped without waiting for m_ack

Ports:
clk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of FIFO contents
s_valid  in  1  beat valid from AXI master
s_ready  out  1  registered ready to AXI master
s_data  in  DATA_W  beat payload
m_cs  out  1  beat available to local logic (pulse in AUTO_POP mode)
m_data  out  DATA_W  payload at FIFO head
m_ack  in  1  local logic consumes head; ignored when AUTO_POP=1
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH

Behaviour:
- Reset (areset=1, asynchronous): FSM=ST_INIT, wr_ptr=rd_ptr=0, count=0, s_ready=0, m_cs=0. m_data is don't-care. Memory is not reset.
- FSM states and transitions:
  - ST_INIT: s_ready=0. Always goes to ST_RUN on the next clock edge, so s_ready rises exactly 1 cycle after areset deasserts.
  - ST_RUN: normal operation. Only areset leaves ST_RUN.
- Push: s_valid && s_ready at a clock edge. mem[wr_ptr] <= s_data and wr_ptr increments.
  - Pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit.
  - Full when the low bits are equal and the wrap bits differ. Empty when the pointers are equal.
- Pop:
  - AUTO_POP=0: a pop occurs on m_cs && m_ack.
  - AUTO_POP=1: a pop occurs whenever m_cs=1.
  - rd_ptr increments on each pop.
- s_ready is registered: s_ready <= (state_next==ST_RUN) && !full_next, with full_next computed after this cycle's push/pop.
  - When full, s_ready=0 even if a pop happens in the same cycle. s_ready returns to 1 on the cycle after that pop.
  - No push is ever possible when full; overflow cannot occur.
- m_cs and m_data:
  - AUTO_POP=0: m_cs = !empty, a combinational decode of the registered pointers. m_data = mem[rd_ptr]. The head is stable while m_cs=1 and m_ack=0.
  - AUTO_POP=1: m_cs is 1 for one cycle per beat, in order. Back-to-back beats give consecutive m_cs cycles.
- Latency: a beat pushed at edge N gives m_cs=1 in the cycle after edge N (1-cycle latency), provided the FIFO was empty.
- Simultaneous push and pop: legal when neither full nor empty. count is unchanged and both pointers advance.
- Pop when empty is ignored. m_ack while m_cs=0 has no effect.
- Wrap-around: pointers wrap modulo 2*DEPTH. Data order is strictly FIFO across wraps.
- count = wr_ptr - rd_ptr, computed modulo 2*DEPTH, width $clog2(DEPTH)+1.
- flush (synchronous, ST_RUN only):
  - Effect at the edge: rd_ptr <= wr_ptr, so count=0 on the next cycle. Any push in the same cycle is discarded.
  - Timing: m_cs=0 in the cycle after the edge.
  - s_ready: unaffected, except that it goes to 1 if the FIFO was full.
- Reset mid-operation: all buffered beats are lost and outputs return to reset values immediately. s_ready rises again 1 cycle after release.

Decomposition:
- Package axi_lite_pkg holds:
  - FSM state encodings ST_INIT=1'b0 and ST_RUN=1'b1
  - AXI-lite response codes OKAY/SLVERR for sibling blocks
  - the pointer-width helper function
- Natural sub-module: axi_lite_fifo_mem, a DEPTH x DATA_W register array with one write port and a combinational read port.
- The FSM, pointers and flag logic stay in the top module.

Test Plan:
1. Release areset at cycle 0 -> s_ready=0 in cycle 0 and 1 from cycle 1. m_cs=0 and count=0 throughout.
2. DEPTH=4, AUTO_POP=0, m_ack=0, push 0xA0..0xA3 back-to-back -> count=4 and s_ready=0 after the 4th beat. A 5th beat 0xA4 is held, not written.
3. From the full state, m_ack=1 for 1 cycle -> m_data was 0xA0. s_ready=1 the next cycle. 0xA4 is accepted one cycle later and count returns to 4.
4. Stream 10 beats 0x00..0x09 with m_ack=1 continuously -> m_data sequence 0x00..0x09 in order across 2 pointer wraps, with count <= 2 throughout.
5. AUTO_POP=1, push 0x11, 0x22, 0x33 back-to-back -> m_cs high for 3 consecutive cycles starting 1 cycle after the first push, with m_data 0x11, 0x22, 0x33.
6. count=3, assert flush together with a push of 0x55 -> count=0 and m_cs=0 next cycle, and 0x55 is never presented. Separately, assert areset while count=2 -> immediate s_ready=0, m_cs=0 and count=0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite slave blocks: FSM encodings, response
// codes and the pointer-width helper.
package axi_lite_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Index bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_lite_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module axi_lite_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_ch_fifo.sv
// AXI-lite channel receiver: VALID/READY slave port buffered into a circular
// FIFO, presented to local register logic on a cs/ack port.
module axi_lite_ch_fifo
    import axi_lite_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AUTO_POP = 0
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_cs,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          s_ready_q, s_ready_d;

    logic empty, full_next, flush_run, push, pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign flush_run = flush && (state_q == ST_RUN);
    // A push coinciding with flush is dropped rather than surviving the clear.
    assign push      = s_valid && s_ready_q && !flush_run;
    assign m_cs      = !empty;
    assign pop       = m_cs && ((AUTO_POP != 0) || m_ack);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = flush_run ? wr_ptr_q : rd_ptr_q + PW'(pop);
    end

    assign full_next = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                       (wr_ptr_d[AW] != rd_ptr_d[AW]);
    // Registered ready looks at post-update occupancy, so a pop while full
    // only reopens the port on the following cycle.
    assign s_ready_d = (state_d == ST_RUN) && !full_next;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_INIT;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            s_ready_q <= s_ready_d;
        end
    end

    axi_lite_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (s_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (m_data)
    );

    assign s_ready = s_ready_q;
    assign count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_axi_lite_ch_fifo.sv
// Directed bench for axi_lite_ch_fifo: one handshake-mode and one auto-pop
// instance, checked against a table of hand-computed cycle vectors.
module tb_axi_lite_ch_fifo;

    logic        clk;
    logic        areset;
    logic        fl0, v0, ack0, rdy0, cs0;
    logic [31:0] d0, dat0;
    logic [2:0]  cnt0;
    logic        fl1, v1, ack1, rdy1, cs1;
    logic [31:0] d1, dat1;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    axi_lite_ch_fifo #(.DATA_W(32), .DEPTH(4), .AUTO_POP(0)) u_hs (
        .clk(clk), .areset(areset), .flush(fl0), .s_valid(v0), .s_ready(rdy0),
        .s_data(d0), .m_cs(cs0), .m_data(dat0), .m_ack(ack0), .count(cnt0)
    );

    axi_lite_ch_fifo #(.DATA_W(32), .DEPTH(4), .AUTO_POP(1)) u_ap (
        .clk(clk), .areset(areset), .flush(fl1), .s_valid(v1), .s_ready(rdy1),
        .s_data(d1), .m_cs(cs1), .m_data(dat1), .m_ack(ack1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ap;
        bit          v;
        logic [31:0] d;
        bit          ack;
        bit          fl;
        bit          rdy;
        bit          cs;
        logic [31:0] dat;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit ap, bit v, logic [31:0] d, bit ack, bit fl,
                                bit rdy, bit cs, logic [31:0] dat, logic [2:0] cnt);
        vec_t r;
        r.ap = ap; r.v = v; r.d = d; r.ack = ack; r.fl = fl;
        r.rdy = rdy; r.cs = cs; r.dat = dat; r.cnt = cnt;
        tv.push_back(r);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_hs(string tag, int idx, bit rdy, bit cs, logic [2:0] cnt);
        chk({tag, "_ready"}, idx, 32'(rdy0), 32'(rdy));
        chk({tag, "_cs"},    idx, 32'(cs0),  32'(cs));
        chk({tag, "_count"}, idx, 32'(cnt0), 32'(cnt));
    endtask

    task automatic idle_inputs();
        v0 = 0; d0 = '0; ack0 = 0; fl0 = 0;
        v1 = 0; d1 = '0; ack1 = 0; fl1 = 0;
    endtask

    initial begin
        idle_inputs();
        areset = 1'b1;

        // Handshake instance: post-reset, fill to full, held 5th beat, pop, refill.
        add(0, 0, 0,     0, 0, 0, 0, 0,     0);
        add(0, 1, 'hA0,  0, 0, 1, 0, 0,     0);
        add(0, 1, 'hA1,  0, 0, 1, 1, 'hA0,  1);
        add(0, 1, 'hA2,  0, 0, 1, 1, 'hA0,  2);
        add(0, 1, 'hA3,  0, 0, 1, 1, 'hA0,  3);
        add(0, 1, 'hA4,  0, 0, 0, 1, 'hA0,  4);
        add(0, 1, 'hA4,  1, 0, 0, 1, 'hA0,  4);
        add(0, 1, 'hA4,  0, 0, 1, 1, 'hA1,  3);
        add(0, 0, 0,     1, 0, 0, 1, 'hA1,  4);
        add(0, 0, 0,     1, 0, 1, 1, 'hA2,  3);
        add(0, 0, 0,     1, 0, 1, 1, 'hA3,  2);
        add(0, 0, 0,     1, 0, 1, 1, 'hA4,  1);
        add(0, 0, 0,     0, 0, 1, 0, 0,     0);
        // Stream 10 beats with ack held high; pointers wrap the array twice.
        for (int k = 0; k < 10; k++)
            add(0, 1, 32'(k), 1, 0, 1, (k != 0), 32'(k - 1), (k != 0) ? 3'd1 : 3'd0);
        add(0, 0, 0,     1, 0, 1, 1, 32'd9, 1);
        add(0, 0, 0,     0, 0, 1, 0, 0,     0);
        // Flush with a simultaneous push at count=3; 0x55 must never appear.
        add(0, 1, 'hB1,  0, 0, 1, 0, 0,     0);
        add(0, 1, 'hB2,  0, 0, 1, 1, 'hB1,  1);
        add(0, 1, 'hB3,  0, 0, 1, 1, 'hB1,  2);
        add(0, 1, 'h55,  0, 1, 1, 1, 'hB1,  3);
        add(0, 0, 0,     0, 0, 1, 0, 0,     0);
        add(0, 1, 'h66,  0, 0, 1, 0, 0,     0);
        add(0, 0, 0,     1, 0, 1, 1, 'h66,  1);
        add(0, 0, 0,     0, 0, 1, 0, 0,     0);
        // Flush while full reopens s_ready.
        add(0, 1, 'hC0,  0, 0, 1, 0, 0,     0);
        add(0, 1, 'hC1,  0, 0, 1, 1, 'hC0,  1);
        add(0, 1, 'hC2,  0, 0, 1, 1, 'hC0,  2);
        add(0, 1, 'hC3,  0, 0, 1, 1, 'hC0,  3);
        add(0, 0, 0,     0, 1, 0, 1, 'hC0,  4);
        add(0, 0, 0,     0, 0, 1, 0, 0,     0);
        // Auto-pop instance: one cs cycle per beat, back to back, ack ignored.
        add(1, 1, 'h11,  0, 0, 1, 0, 0,     0);
        add(1, 1, 'h22,  0, 0, 1, 1, 'h11,  1);
        add(1, 1, 'h33,  0, 0, 1, 1, 'h22,  1);
        add(1, 0, 0,     0, 0, 1, 1, 'h33,  1);
        add(1, 0, 0,     1, 0, 1, 0, 0,     0);

        repeat (2) @(negedge clk);
        #1;
        chk_hs("rst_hs", -1, 0, 0, 0);
        chk("rst_ap_ready", -1, 32'(rdy1), 0);
        chk("rst_ap_cs",    -1, 32'(cs1),  0);
        chk("rst_ap_count", -1, 32'(cnt1), 0);
        @(negedge clk);
        areset = 1'b0;

        foreach (tv[i]) begin
            idle_inputs();
            if (tv[i].ap) begin
                v1 = tv[i].v; d1 = tv[i].d; ack1 = tv[i].ack; fl1 = tv[i].fl;
            end else begin
                v0 = tv[i].v; d0 = tv[i].d; ack0 = tv[i].ack; fl0 = tv[i].fl;
            end
            #1;
            chk("ready", i, tv[i].ap ? 32'(rdy1) : 32'(rdy0), 32'(tv[i].rdy));
            chk("cs",    i, tv[i].ap ? 32'(cs1)  : 32'(cs0),  32'(tv[i].cs));
            chk("count", i, tv[i].ap ? 32'(cnt1) : 32'(cnt0), 32'(tv[i].cnt));
            if (tv[i].cs)
                chk("data", i, tv[i].ap ? dat1 : dat0, tv[i].dat);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset in mid-operation with two beats buffered.
        idle_inputs();
        v0 = 1; d0 = 'hE1;
        @(negedge clk);
        d0 = 'hE2;
        @(negedge clk);
        idle_inputs();
        #1;
        chk_hs("pre_rst", 100, 1, 1, 2);
        chk("pre_rst_data", 100, dat0, 'hE1);
        #2 areset = 1'b1;
        #1;
        chk_hs("mid_rst", 101, 0, 0, 0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk_hs("rel0", 102, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_hs("rel1", 103, 1, 0, 0);
        chk("rel1_ap_ready", 103, 32'(rdy1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
